// File: rtl/coffee_vend_ctrl.sv
// Coffee machine sequencer: collects coins, checks prices, drives the brewer
// handshake and pays change greedily through the coin-out handshake.
module coffee_vend_ctrl #(
    parameter int unsigned PRICE_CAFE         = 150,
    parameter int unsigned PRICE_CAPUCCINO    = 300,
    parameter int unsigned PRICE_CAFE_LONGO   = 200,
    parameter int unsigned PRICE_ACHOCOLATADO = 250,
    parameter int unsigned MAX_CREDIT         = 2000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        coin_valid,
    input  logic [2:0]  dinheiro,
    input  logic        select_valid,
    input  logic [1:0]  selec_produto,
    input  logic        cancel,
    input  logic        brew_done,
    input  logic        coin_out_ack,
    output logic [11:0] credit,
    output logic        brew_start,
    output logic [1:0]  produto_out,
    output logic        coin_out_valid,
    output logic [2:0]  coin_out,
    output logic        coin_reject,
    output logic        insufficient,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, BREW, CHANGE} state_t;

    state_t      state_q, state_d;
    logic [11:0] credit_q, credit_d;
    logic        brew_start_q, brew_start_d;
    logic [1:0]  produto_q, produto_d;
    logic        coin_out_valid_q, coin_out_valid_d;
    logic [2:0]  coin_out_q, coin_out_d;
    logic        coin_reject_q, coin_reject_d;
    logic        insufficient_q, insufficient_d;
    logic        busy_q, busy_d;
    logic [12:0] coin_sum;
    logic [11:0] sel_price;

    function automatic logic [11:0] coin_value(input logic [2:0] code);
        case (code)
            3'd0:    coin_value = 12'd5;
            3'd1:    coin_value = 12'd10;
            3'd2:    coin_value = 12'd25;
            3'd3:    coin_value = 12'd50;
            3'd4:    coin_value = 12'd100;
            3'd5:    coin_value = 12'd200;
            3'd6:    coin_value = 12'd500;
            default: coin_value = 12'd1000;
        endcase
    endfunction

    // Largest denomination that still fits in the remaining credit.
    function automatic logic [2:0] greedy_coin(input logic [11:0] amount);
        if (amount >= 12'd1000)     greedy_coin = 3'd7;
        else if (amount >= 12'd500) greedy_coin = 3'd6;
        else if (amount >= 12'd200) greedy_coin = 3'd5;
        else if (amount >= 12'd100) greedy_coin = 3'd4;
        else if (amount >= 12'd50)  greedy_coin = 3'd3;
        else if (amount >= 12'd25)  greedy_coin = 3'd2;
        else if (amount >= 12'd10)  greedy_coin = 3'd1;
        else                        greedy_coin = 3'd0;
    endfunction

    always_comb begin
        case (selec_produto)
            2'd0:    sel_price = 12'(PRICE_CAFE);
            2'd1:    sel_price = 12'(PRICE_CAPUCCINO);
            2'd2:    sel_price = 12'(PRICE_CAFE_LONGO);
            default: sel_price = 12'(PRICE_ACHOCOLATADO);
        endcase
    end

    always_comb begin
        coin_sum         = {1'b0, credit_q} + {1'b0, coin_value(dinheiro)};
        state_d          = state_q;
        credit_d         = credit_q;
        brew_start_d     = brew_start_q;
        produto_d        = produto_q;
        coin_out_valid_d = coin_out_valid_q;
        coin_out_d       = coin_out_q;
        coin_reject_d    = 1'b0;
        insufficient_d   = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    if (state_q == COLLECT) begin
                        if (credit_q == 12'd0) begin
                            state_d = IDLE;
                        end else begin
                            state_d          = CHANGE;
                            coin_out_valid_d = 1'b1;
                            coin_out_d       = greedy_coin(credit_q);
                        end
                    end
                end else if (select_valid) begin
                    coin_reject_d = coin_valid;
                    if (state_q == COLLECT && credit_q >= sel_price) begin
                        credit_d     = credit_q - sel_price;
                        produto_d    = selec_produto;
                        brew_start_d = 1'b1;
                        state_d      = BREW;
                    end else begin
                        insufficient_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_sum <= 13'(MAX_CREDIT)) begin
                        credit_d = coin_sum[11:0];
                        state_d  = COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            BREW: begin
                coin_reject_d = coin_valid;
                if (brew_done) begin
                    brew_start_d = 1'b0;
                    produto_d    = 2'd0;
                    if (credit_q != 12'd0) begin
                        state_d          = CHANGE;
                        coin_out_valid_d = 1'b1;
                        coin_out_d       = greedy_coin(credit_q);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CHANGE: begin
                coin_reject_d = coin_valid;
                // After each ack, valid is held low for one cycle before the next coin.
                if (coin_out_valid_q) begin
                    if (coin_out_ack) begin
                        credit_d         = credit_q - coin_value(coin_out_q);
                        coin_out_valid_d = 1'b0;
                        coin_out_d       = 3'd0;
                        if (credit_d == 12'd0) state_d = IDLE;
                    end
                end else begin
                    coin_out_valid_d = 1'b1;
                    coin_out_d       = greedy_coin(credit_q);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == BREW) || (state_d == CHANGE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            credit_q         <= 12'd0;
            brew_start_q     <= 1'b0;
            produto_q        <= 2'd0;
            coin_out_valid_q <= 1'b0;
            coin_out_q       <= 3'd0;
            coin_reject_q    <= 1'b0;
            insufficient_q   <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            credit_q         <= credit_d;
            brew_start_q     <= brew_start_d;
            produto_q        <= produto_d;
            coin_out_valid_q <= coin_out_valid_d;
            coin_out_q       <= coin_out_d;
            coin_reject_q    <= coin_reject_d;
            insufficient_q   <= insufficient_d;
            busy_q           <= busy_d;
        end
    end

    assign credit         = credit_q;
    assign brew_start     = brew_start_q;
    assign produto_out    = produto_q;
    assign coin_out_valid = coin_out_valid_q;
    assign coin_out       = coin_out_q;
    assign coin_reject    = coin_reject_q;
    assign insufficient   = insufficient_q;
    assign busy           = busy_q;

endmodule
